// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX back end: branch resolve, fetch redirect, EX/MEM register, branch stats.
// Optional macro EX_BRANCH_FULL_EN enables BLT/BGE/BLTU/BGEU conditions.
module ex_mem_stage #(
  parameter int XLEN  = 32,
  parameter int RD_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StallM,
  input  logic             FlushM,
  input  logic             CntClr,
  input  logic             ValidE,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  input  logic [1:0]       ResultSrcE,
  input  logic             BranchE,
  input  logic             JumpE,
  input  logic             JalrE,
  input  logic [2:0]       Funct3E,
  input  logic [XLEN-1:0]  ALUResultE,
  input  logic             ZeroE,
  input  logic             NegativeE,
  input  logic             OverFlowE,
  input  logic             CarryE,
  input  logic [XLEN-1:0]  WriteDataE,
  input  logic [RD_W-1:0]  RdE,
  input  logic [XLEN-1:0]  PCE,
  input  logic [XLEN-1:0]  PCPlus4E,
  input  logic [XLEN-1:0]  ImmExtE,
  output logic             PCSrcE,
  output logic [XLEN-1:0]  PCTargetE,
  output logic             ValidM,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic [1:0]       ResultSrcM,
  output logic [XLEN-1:0]  ALUResultM,
  output logic [XLEN-1:0]  WriteDataM,
  output logic [XLEN-1:0]  PCPlus4M,
  output logic [RD_W-1:0]  RdM,
  output logic             MisalignM,
  output logic [CNT_W-1:0] BranchCnt,
  output logic [CNT_W-1:0] TakenCnt
);

  logic cond;
  logic load;

  always_comb begin
    cond = 1'b0;
    case (Funct3E)
      3'b000: cond = ZeroE;
      3'b001: cond = ~ZeroE;
`ifdef EX_BRANCH_FULL_EN
      3'b100: cond = NegativeE ^ OverFlowE;
      3'b101: cond = ~(NegativeE ^ OverFlowE);
      3'b110: cond = ~CarryE;
      3'b111: cond = CarryE;
`endif
      default: cond = 1'b0;
    endcase
  end

`ifndef EX_BRANCH_FULL_EN
  logic unused_flags;
  assign unused_flags = NegativeE ^ OverFlowE ^ CarryE;
`endif

  assign PCTargetE = JalrE ? {ALUResultE[XLEN-1:1], 1'b0} : PCE + ImmExtE;
  assign PCSrcE    = ValidE & (JumpE | (BranchE & cond));
  assign load      = ~FlushM & ~StallM;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ValidM     <= 1'b0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      RdM        <= '0;
      MisalignM  <= 1'b0;
    end else if (FlushM) begin
      ValidM     <= 1'b0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      RdM        <= '0;
      MisalignM  <= 1'b0;
    end else if (!StallM) begin
      ValidM     <= ValidE;
      RegWriteM  <= RegWriteE & ValidE;
      MemWriteM  <= MemWriteE & ValidE;
      ResultSrcM <= ResultSrcE;
      ALUResultM <= ALUResultE;
      WriteDataM <= WriteDataE;
      PCPlus4M   <= PCPlus4E;
      RdM        <= RdE;
      MisalignM  <= PCSrcE & PCTargetE[1];
    end
  end

  // Counting only on load cycles keeps a stalled instruction from being counted repeatedly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      BranchCnt <= '0;
      TakenCnt  <= '0;
    end else if (CntClr) begin
      BranchCnt <= '0;
      TakenCnt  <= '0;
    end else if (load) begin
      if (ValidE && BranchE && (BranchCnt != {CNT_W{1'b1}}))
        BranchCnt <= BranchCnt + 1'b1;
      if (PCSrcE && (TakenCnt != {CNT_W{1'b1}}))
        TakenCnt <= TakenCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - scoreboard bench for ex_mem_stage with a behavioural reference model.
module tb_ex_mem_stage;
  localparam int XLEN  = 32;
  localparam int RD_W  = 5;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 0;
  logic rst = 1;
  logic StallM = 0, FlushM = 0, CntClr = 0, ValidE = 0, RegWriteE = 0, MemWriteE = 0;
  logic [1:0] ResultSrcE = 0;
  logic BranchE = 0, JumpE = 0, JalrE = 0;
  logic [2:0] Funct3E = 0;
  logic [XLEN-1:0] ALUResultE = 0;
  logic ZeroE = 0, NegativeE = 0, OverFlowE = 0, CarryE = 0;
  logic [XLEN-1:0] WriteDataE = 0;
  logic [RD_W-1:0] RdE = 0;
  logic [XLEN-1:0] PCE = 0, PCPlus4E = 0, ImmExtE = 0;
  logic PCSrcE;
  logic [XLEN-1:0] PCTargetE;
  logic ValidM, RegWriteM, MemWriteM;
  logic [1:0] ResultSrcM;
  logic [XLEN-1:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [RD_W-1:0] RdM;
  logic MisalignM;
  logic [CNT_W-1:0] BranchCnt, TakenCnt;

  ex_mem_stage #(.XLEN(XLEN), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .StallM(StallM), .FlushM(FlushM), .CntClr(CntClr),
    .ValidE(ValidE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .BranchE(BranchE), .JumpE(JumpE), .JalrE(JalrE), .Funct3E(Funct3E),
    .ALUResultE(ALUResultE), .ZeroE(ZeroE), .NegativeE(NegativeE), .OverFlowE(OverFlowE),
    .CarryE(CarryE), .WriteDataE(WriteDataE), .RdE(RdE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .ImmExtE(ImmExtE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ValidM(ValidM),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM),
    .MisalignM(MisalignM), .BranchCnt(BranchCnt), .TakenCnt(TakenCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic stall, flush, clr, valid, regw, memw;
    logic [1:0] rsrc;
    logic branch, jump, jalr;
    logic [2:0] f3;
    logic [31:0] alu;
    logic zero, neg, ovf, carry;
    logic [31:0] wd;
    logic [4:0] rd;
    logic [31:0] pc, pc4, imm;
  } stim_t;

  typedef struct {
    logic pcsrc;
    logic [31:0] target;
    logic valid, regw, memw;
    logic [1:0] rsrc;
    logic [31:0] alu, wd, pc4;
    logic [4:0] rd;
    logic misalign;
    int bcnt, tcnt;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // Monitor: every falling edge compares whatever the stimulus side promised for this cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("PCSrcE", 32'(PCSrcE), 32'(e.pcsrc));
        chk("PCTargetE", PCTargetE, e.target);
        chk("ValidM", 32'(ValidM), 32'(e.valid));
        chk("RegWriteM", 32'(RegWriteM), 32'(e.regw));
        chk("MemWriteM", 32'(MemWriteM), 32'(e.memw));
        chk("ResultSrcM", 32'(ResultSrcM), 32'(e.rsrc));
        chk("ALUResultM", ALUResultM, e.alu);
        chk("WriteDataM", WriteDataM, e.wd);
        chk("PCPlus4M", PCPlus4M, e.pc4);
        chk("RdM", 32'(RdM), 32'(e.rd));
        chk("MisalignM", 32'(MisalignM), 32'(e.misalign));
        chk("BranchCnt", 32'(BranchCnt), 32'(e.bcnt));
        chk("TakenCnt", 32'(TakenCnt), 32'(e.tcnt));
      end
    end
  end

  function automatic logic branch_cond(input stim_t s);
    logic lt_signed = s.neg ^ s.ovf;
    case (s.f3)
      3'd0: return s.zero;
      3'd1: return !s.zero;
`ifdef EX_BRANCH_FULL_EN
      3'd4: return lt_signed;
      3'd5: return !lt_signed;
      3'd6: return !s.carry;
      3'd7: return s.carry;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic stim_t base();
    stim_t s;
    s = '{default: '0};
    s.valid = 1'b1;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.stall  = ($urandom_range(0, 4) == 0);
    s.flush  = ($urandom_range(0, 9) == 0);
    s.clr    = ($urandom_range(0, 19) == 0);
    s.valid  = ($urandom_range(0, 5) != 0);
    s.regw   = 1'($urandom);
    s.memw   = 1'($urandom);
    s.rsrc   = 2'($urandom);
    s.branch = 1'($urandom);
    s.jump   = ($urandom_range(0, 3) == 0);
    s.jalr   = 1'($urandom);
    s.f3     = 3'($urandom);
    s.alu    = $urandom;
    s.zero   = 1'($urandom);
    s.neg    = 1'($urandom);
    s.ovf    = 1'($urandom);
    s.carry  = 1'($urandom);
    s.wd     = $urandom;
    s.rd     = 5'($urandom);
    s.pc     = $urandom;
    s.pc4    = s.pc + 32'd4;
    s.imm    = $urandom;
    return s;
  endfunction

  task automatic step(input stim_t s, input bit do_rst);
    exp_t e;
    logic taken;
    logic [31:0] tgt;
    @(posedge clk);
    #2;
    if (do_rst) begin
      rst = 1'b1;
      m = '{default: '0};
    end
    StallM = s.stall; FlushM = s.flush; CntClr = s.clr; ValidE = s.valid;
    RegWriteE = s.regw; MemWriteE = s.memw; ResultSrcE = s.rsrc;
    BranchE = s.branch; JumpE = s.jump; JalrE = s.jalr; Funct3E = s.f3;
    ALUResultE = s.alu; ZeroE = s.zero; NegativeE = s.neg; OverFlowE = s.ovf;
    CarryE = s.carry; WriteDataE = s.wd; RdE = s.rd; PCE = s.pc;
    PCPlus4E = s.pc4; ImmExtE = s.imm;

    tgt   = s.jalr ? (s.alu & ~32'd1) : (s.pc + s.imm);
    taken = s.valid && (s.jump || (s.branch && branch_cond(s)));
    e = m;
    e.pcsrc  = taken;
    e.target = tgt;
    q.push_back(e);

    if (s.flush) begin
      m.valid = 0; m.regw = 0; m.memw = 0; m.rsrc = 0; m.alu = 0;
      m.wd = 0; m.pc4 = 0; m.rd = 0; m.misalign = 0;
    end else if (!s.stall) begin
      m.valid = s.valid; m.regw = s.regw && s.valid; m.memw = s.memw && s.valid;
      m.rsrc = s.rsrc; m.alu = s.alu; m.wd = s.wd; m.pc4 = s.pc4; m.rd = s.rd;
      m.misalign = taken && (tgt % 4 >= 2);
    end
    if (s.clr) begin
      m.bcnt = 0;
      m.tcnt = 0;
    end else if (!s.flush && !s.stall) begin
      if (s.valid && s.branch) m.bcnt = (m.bcnt + 1 > CMAX) ? CMAX : m.bcnt + 1;
      if (taken) m.tcnt = (m.tcnt + 1 > CMAX) ? CMAX : m.tcnt + 1;
    end
    if (do_rst) begin
      #4;
      rst = 1'b0;
    end
  endtask

  initial begin
    stim_t s;
    m = '{default: '0};
    repeat (2) @(posedge clk);
    step(base(), 1'b1);

    // Directed: BEQ taken to 0x120.
    s = base(); s.branch = 1; s.f3 = 3'd0; s.zero = 1; s.pc = 32'h100; s.imm = 32'h20;
    s.pc4 = 32'h104;
    step(s, 1'b0);
    step(base(), 1'b0);

    // Directed: JALR to 0x203 -> target 0x202, misaligned.
    s = base(); s.jump = 1; s.jalr = 1; s.alu = 32'h203; s.pc4 = 32'h0000_0abc; s.regw = 1;
    step(s, 1'b0);
    step(base(), 1'b0);

    // Directed: stall three cycles on a branch carrying 0xA5, then release.
    s = base(); s.branch = 1; s.f3 = 3'd1; s.zero = 1; s.alu = 32'hA5; s.stall = 1;
    repeat (3) step(s, 1'b0);
    s.stall = 0;
    step(s, 1'b0);
    step(base(), 1'b0);

    // Directed: stall and flush together.
    s = base(); s.regw = 1; s.memw = 1; s.stall = 1; s.flush = 1;
    step(s, 1'b0);
    step(base(), 1'b0);

    // Directed: BLT with N=1, V=0.
    s = base(); s.branch = 1; s.f3 = 3'd4; s.neg = 1; s.ovf = 0; s.pc = 32'h400; s.imm = 32'h10;
    step(s, 1'b0);
    step(base(), 1'b0);

    // Random traffic with a mid-run async reset.
    for (int i = 0; i < 300; i++) begin
      step(rand_stim(), (i == 150));
    end

    // Saturate both counters and keep pushing.
    s = base(); s.branch = 1; s.f3 = 3'd0; s.zero = 1; s.pc = 32'h800; s.imm = 32'h4;
    for (int i = 0; i < CMAX + 20; i++) step(s, 1'b0);
    s = base(); s.jump = 1; s.pc = 32'h900; s.imm = 32'h8;
    repeat (5) step(s, 1'b0);
    s.clr = 1;
    step(s, 1'b0);
    step(base(), 1'b0);

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
